box_blur_engine: RTL

Parametrised KxK box-blur accelerator that replaces the software-sum plus fixed divide-by-9 path. On a start pulse from a Nios PIO, it reads a source frame from one pixel-buffer port and writes the blurred frame to a destination region. Edge pixels are clamped and every output is exactly floor(sum/K²). It sits between the Nios PIOs and the 2-port pixel RAM, and shares the RAM write port with the processor through a top-level mux selected by `BUSY`.

---
 rtl/blur_pkg.sv | 27 ++
 rtl/win_addr_gen.sv | 53 +++++
 rtl/box_blur_engine.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/blur_pkg.sv
// Shared encodings and width helpers for the box-blur accelerator.
package blur_pkg;

  localparam logic [1:0] MODE_BLUR   = 2'd0;
  localparam logic [1:0] MODE_COPY   = 2'd1;
  localparam logic [1:0] MODE_INVERT = 2'd2;
  localparam logic [1:0] MODE_RSVD   = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_DRAIN,
    S_WRITE,
    S_FINISH
  } blur_state_e;

  // Wide enough to hold K*K samples of full-scale pixels without overflow.
  function automatic int acc_width(input int pix_w, input int k);
    return pix_w + $clog2(k * k);
  endfunction

  // Bits needed to count 0..n-1, never less than one.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/win_addr_gen.sv
// Window address generator: clamps (x+kx-rad, y+ky-rad) into the frame and
// turns it into a linear pixel address, registered once so that the address
// presented to the RAM is stable for a full cycle.
module win_addr_gen
  import blur_pkg::*;
#(
  parameter int IMG_W  = 160,
  parameter int IMG_H  = 120,
  parameter int ADDR_W = 15,
  parameter int XW     = cnt_width(IMG_W),
  parameter int YW     = cnt_width(IMG_H),
  parameter int KW     = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [XW-1:0]     x,
  input  logic [YW-1:0]     y,
  input  logic [KW-1:0]     kx,
  input  logic [KW-1:0]     ky,
  input  logic [KW-1:0]     rad,
  input  logic [ADDR_W-1:0] base,
  output logic [ADDR_W-1:0] addr
);

  localparam int CW = (XW > YW) ? XW : YW;
  localparam int SW = CW + KW + 2;
  localparam logic signed [SW-1:0] MAX_X = SW'(IMG_W - 1);
  localparam logic signed [SW-1:0] MAX_Y = SW'(IMG_H - 1);

  logic signed [SW-1:0] cx, cy, cx_c, cy_c;
  logic [ADDR_W-1:0]    addr_c;

  // Signed window coordinate, clamped to the frame edges, then linearised.
  always_comb begin
    cx = $signed(SW'(x)) + $signed(SW'(kx)) - $signed(SW'(rad));
    cy = $signed(SW'(y)) + $signed(SW'(ky)) - $signed(SW'(rad));
    if (cx[SW-1])       cx_c = '0;
    else if (cx > MAX_X) cx_c = MAX_X;
    else                 cx_c = cx;
    if (cy[SW-1])       cy_c = '0;
    else if (cy > MAX_Y) cy_c = MAX_Y;
    else                 cy_c = cy;
    addr_c = base + ADDR_W'(cy_c) * ADDR_W'(IMG_W) + ADDR_W'(cx_c);
  end

  // Address register; holds its value whenever no new window slot is loaded.
  always_ff @(posedge clk) begin
    if (reset)     addr <= '0;
    else if (load) addr <= addr_c;
  end

endmodule

// File: rtl/box_blur_engine.sv
// KxK box-blur / copy / invert engine. Walks the frame pixel by pixel,
// reading the clamped window one sample per cycle, then writes one result.
module box_blur_engine
  import blur_pkg::*;
#(
  parameter int PIX_W  = 4,
  parameter int IMG_W  = 160,
  parameter int IMG_H  = 120,
  parameter int ADDR_W = 15,
  parameter int KSIZE  = 3
) (
  input  logic              CLOCK_50,
  input  logic              RESET,
  input  logic              START,
  input  logic [1:0]        MODE,
  input  logic [ADDR_W-1:0] SRC_BASE,
  input  logic [ADDR_W-1:0] DST_BASE,
  output logic [ADDR_W-1:0] RD_ADDR,
  input  logic [PIX_W-1:0]  RD_DATA,
  output logic [ADDR_W-1:0] WR_ADDR,
  output logic [PIX_W-1:0]  WR_DATA,
  output logic              WR_EN,
  output logic              BUSY,
  output logic              DONE,
  output logic              DONE_FLAG
);

  localparam int XW    = cnt_width(IMG_W);
  localparam int YW    = cnt_width(IMG_H);
  localparam int KW    = cnt_width(KSIZE);
  localparam int ACC_W = acc_width(PIX_W, KSIZE);
  localparam int RAD   = (KSIZE - 1) / 2;
  localparam int KK    = KSIZE * KSIZE;

  blur_state_e       state;
  logic              start_q;
  logic [1:0]        mode_q;
  logic [ADDR_W-1:0] src_q, dst_q;
  logic [KW-1:0]     k_last_q, rad_q;
  logic [XW-1:0]     x, x_nxt;
  logic [YW-1:0]     y, y_nxt;
  logic [KW-1:0]     kx, ky, kx_nxt, ky_nxt;
  logic [ACC_W-1:0]  acc, acc_sum, blur_q;
  logic [PIX_W-1:0]  pix_out;
  logic              start_edge, win_first, win_last, x_last, frame_last;

  logic [XW-1:0]     gen_x;
  logic [YW-1:0]     gen_y;
  logic [KW-1:0]     gen_kx, gen_ky, gen_rad;
  logic [ADDR_W-1:0] gen_base;
  logic              gen_load;

  assign start_edge = START & ~start_q;
  assign win_first  = (kx == '0) && (ky == '0);
  assign win_last   = (kx == k_last_q) && (ky == k_last_q);
  assign x_last     = (x == XW'(IMG_W - 1));
  assign frame_last = x_last && (y == YW'(IMG_H - 1));
  assign acc_sum    = acc + ACC_W'(RD_DATA);
  assign blur_q     = acc_sum / ACC_W'(KK);

  // Next window slot (kx inner, ky outer) and next raster position.
  always_comb begin
    kx_nxt = (kx == k_last_q) ? '0 : kx + KW'(1);
    ky_nxt = (kx == k_last_q) ? ky + KW'(1) : ky;
    x_nxt  = x_last ? '0 : x + XW'(1);
    y_nxt  = x_last ? y + YW'(1) : y;
  end

  // Output pixel from the complete window sum; copy/invert see one sample.
  always_comb begin
    pix_out = PIX_W'(acc_sum);
    case (mode_q)
      MODE_BLUR:            pix_out = PIX_W'(blur_q);
      MODE_INVERT:          pix_out = {PIX_W{1'b1}} - PIX_W'(acc_sum);
      MODE_COPY, MODE_RSVD: pix_out = PIX_W'(acc_sum);
      default:              pix_out = PIX_W'(acc_sum);
    endcase
  end

  // Chooses which window slot the address register loads this cycle, so the
  // next read address is already on RD_ADDR when the following cycle begins.
  always_comb begin
    gen_x    = x;
    gen_y    = y;
    gen_kx   = '0;
    gen_ky   = '0;
    gen_rad  = rad_q;
    gen_base = src_q;
    gen_load = 1'b0;
    case (state)
      S_IDLE: if (start_edge) begin
        gen_x    = '0;
        gen_y    = '0;
        gen_rad  = (MODE == MODE_BLUR) ? KW'(RAD) : '0;
        gen_base = SRC_BASE;
        gen_load = 1'b1;
      end
      S_READ: if (!win_last) begin
        gen_kx   = kx_nxt;
        gen_ky   = ky_nxt;
        gen_load = 1'b1;
      end
      S_WRITE: if (!frame_last) begin
        gen_x    = x_nxt;
        gen_y    = y_nxt;
        gen_load = 1'b1;
      end
      default: gen_load = 1'b0;
    endcase
  end

  win_addr_gen #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .ADDR_W(ADDR_W),
    .XW    (XW),
    .YW    (YW),
    .KW    (KW)
  ) u_addr (
    .clk  (CLOCK_50),
    .reset(RESET),
    .load (gen_load),
    .x    (gen_x),
    .y    (gen_y),
    .kx   (gen_kx),
    .ky   (gen_ky),
    .rad  (gen_rad),
    .base (gen_base),
    .addr (RD_ADDR)
  );

  // Frame sequencer with registered write port and status outputs.
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      state     <= S_IDLE;
      start_q   <= START;
      mode_q    <= MODE_BLUR;
      src_q     <= '0;
      dst_q     <= '0;
      k_last_q  <= '0;
      rad_q     <= '0;
      x         <= '0;
      y         <= '0;
      kx        <= '0;
      ky        <= '0;
      acc       <= '0;
      WR_ADDR   <= '0;
      WR_DATA   <= '0;
      WR_EN     <= 1'b0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
      DONE_FLAG <= 1'b0;
    end else begin
      start_q <= START;
      WR_EN   <= 1'b0;
      DONE    <= 1'b0;
      case (state)
        S_IDLE: if (start_edge) begin
          mode_q    <= MODE;
          src_q     <= SRC_BASE;
          dst_q     <= DST_BASE;
          k_last_q  <= (MODE == MODE_BLUR) ? KW'(KSIZE - 1) : '0;
          rad_q     <= (MODE == MODE_BLUR) ? KW'(RAD) : '0;
          x         <= '0;
          y         <= '0;
          kx        <= '0;
          ky        <= '0;
          acc       <= '0;
          DONE_FLAG <= 1'b0;
          BUSY      <= 1'b1;
          state     <= S_READ;
        end
        S_READ: begin
          if (!win_first) acc <= acc_sum;
          if (win_last) begin
            state <= S_DRAIN;
          end else begin
            kx <= kx_nxt;
            ky <= ky_nxt;
          end
        end
        S_DRAIN: begin
          acc     <= acc_sum;
          WR_EN   <= 1'b1;
          WR_DATA <= pix_out;
          WR_ADDR <= dst_q + ADDR_W'(y) * ADDR_W'(IMG_W) + ADDR_W'(x);
          state   <= S_WRITE;
        end
        S_WRITE: begin
          acc <= '0;
          kx  <= '0;
          ky  <= '0;
          if (frame_last) begin
            BUSY      <= 1'b0;
            DONE      <= 1'b1;
            DONE_FLAG <= 1'b1;
            state     <= S_FINISH;
          end else begin
            x     <= x_nxt;
            y     <= y_nxt;
            state <= S_READ;
          end
        end
        S_FINISH: state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

endmodule
